// File: rtl/word_tx_17bit.sv
// Framed serial transmitter: start, 17 data bits MSB first, even parity, stop.
// Each bit is held for CLKS_PER_BIT clocks; every output comes straight from a flop.
module word_tx_17bit #(
    parameter int unsigned WIDTH        = 17,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               baud_last;

    // State and datapath registers; the whole frame is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so each flop
    // shows the value belonging to the cycle it is entering.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        baud_last = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = baud_last ? '0 : baud_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = data_in;
                    par_d   = ^data_in;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d   = DATA;
                    bit_cnt_d = BIT_LAST;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = shift_q << 1;
                    if (bit_cnt_q == '0) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[WIDTH-1];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        done_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign tx    = tx_q;
    assign done  = done_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_word_tx_17bit.sv
// Bench for word_tx_17bit: two instances (4 and 1 clocks per bit) checked
// cycle by cycle against a frame built from the data word.
module tb_word_tx_17bit;

    logic        clk;
    logic        rst_n;
    logic [16:0] data_in;
    logic        load4, load1;
    logic        ready4, tx4, busy4, done4;
    logic        ready1, tx1, busy1, done1;
    logic        sel;
    int          tests;
    int          fails;
    int          cyc;
    int          last_done_cyc;

    word_tx_17bit #(.WIDTH(17), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load4),
        .ready(ready4), .tx(tx4), .busy(busy4), .done(done4)
    );

    word_tx_17bit #(.WIDTH(17), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    wire tx_s    = sel ? tx1    : tx4;
    wire ready_s = sel ? ready1 : ready4;
    wire busy_s  = sel ? busy1  : busy4;
    wire done_s  = sel ? done1  : done4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_load(input logic v);
        load4 = sel ? 1'b0 : v;
        load1 = sel ? v : 1'b0;
    endtask

    // Expected line level for bit slot idx of the frame carrying d.
    function automatic logic frame_bit(input logic [16:0] d, input int idx);
        logic [16:0] w;
        w = d;
        if (idx == 0)  return 1'b0;
        if (idx <= 17) return w[17 - idx];
        if (idx == 18) return logic'($countones(w) % 2);
        return 1'b1;
    endfunction

    // Called at a negedge with the selected DUT idle. Sends d and follows it
    // cycle by cycle; inject_k >= 0 pokes a busy load plus new data mid-frame.
    task automatic frame(input logic [16:0] d, input int inject_k, input bit keep_load);
        int cpb;
        int n;
        cpb = sel ? 1 : 4;
        n   = 20 * cpb;
        check("ready_pre", 32'(ready_s), 32'd1);
        data_in = d;
        drive_load(1'b1);
        @(negedge clk);
        if (!keep_load) drive_load(1'b0);
        data_in = 17'($urandom);
        for (int k = 0; k < n; k++) begin
            check("tx", 32'(tx_s), 32'(frame_bit(d, k / cpb)));
            check("done", 32'(done_s), 32'(k == n - 1));
            check("busy", 32'(busy_s), 32'd1);
            check("ready", 32'(ready_s), 32'd0);
            if (done_s) last_done_cyc = cyc;
            if (k == inject_k) begin
                data_in = 17'h1FFFF;
                drive_load(1'b1);
            end else if (k == inject_k + 1) begin
                data_in = 17'($urandom);
                drive_load(1'b0);
            end
            @(negedge clk);
        end
        check("ready_post", 32'(ready_s), 32'd1);
        check("busy_post", 32'(busy_s), 32'd0);
        check("tx_idle", 32'(tx_s), 32'd1);
        check("done_post", 32'(done_s), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_tx", 32'(tx_s), 32'd1);
            check("idle_ready", 32'(ready_s), 32'd1);
            check("idle_done", 32'(done_s), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int first_done;
        tests = 0;
        fails = 0;
        cyc = 0;
        last_done_cyc = -1;
        sel = 1'b0;
        rst_n = 1'b0;
        data_in = '0;
        load4 = 1'b0;
        load1 = 1'b0;

        // Reset state and quiet idle line.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx4), 32'd1);
        check("rst_ready", 32'(ready4), 32'd1);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        idle_cycles(10);

        // Fixed patterns, including parity extremes.
        frame(17'h15555, -1, 1'b0);
        frame(17'h00000, -1, 1'b0);
        frame(17'h1FFFF, -1, 1'b0);
        frame(17'h10000, -1, 1'b0);

        // Load and data changes while busy are ignored; no second frame follows.
        frame(17'h00001, 30, 1'b0);
        idle_cycles(8);

        // Back-to-back frames with load held high.
        frame(17'h0AAAA, -1, 1'b1);
        first_done = last_done_cyc;
        frame(17'h15555, -1, 1'b0);
        check("done_gap", 32'(last_done_cyc - first_done), 32'd81);

        // Random words, some with a mid-frame busy load.
        for (int i = 0; i < 6; i++) begin
            frame(17'($urandom), (i % 2 == 0) ? int'($urandom_range(5, 70)) : -1, 1'b0);
        end

        // Reset in the middle of DATA.
        data_in = 17'h0F0F0;
        drive_load(1'b1);
        @(negedge clk);
        drive_load(1'b0);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx4), 32'd1);
        check("mid_rst_ready", 32'(ready4), 32'd1);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_done", 32'(done4), 32'd0);
        @(negedge clk);
        check("rst_hold_tx", 32'(tx4), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        idle_cycles(2);
        frame(17'h0F0F0, -1, 1'b0);

        // One clock per bit.
        sel = 1'b1;
        idle_cycles(2);
        frame(17'h15555, -1, 1'b0);
        frame(17'h0AAAA, -1, 1'b1);
        first_done = last_done_cyc;
        frame(17'h1FFFF, -1, 1'b0);
        check("done_gap1", 32'(last_done_cyc - first_done), 32'd21);
        for (int i = 0; i < 6; i++) begin
            frame(17'($urandom), (i % 2 == 0) ? int'($urandom_range(2, 15)) : -1, 1'b0);
        end
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
